relu_stream_sequencer: RTL and testbench

- Takes one full vector of NUM_NODES pre-activation values from a dense layer. Applies ReLU, or pass-through in bypass mode.
- Streams the result to the next layer or activation buffer, LANES elements per beat, over a valid/ready handshake.
- Time-multiplexes a narrow downstream datapath across the wide layer output.
- Reports per-vector completion and a count of clamped elements.

---
 rtl/relu_stream_sequencer.sv | 164 ++++++++++++++++
 tb/tb_relu_stream_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_stream_sequencer.sv
// ReLU / bypass stage that captures a full dense-layer output vector and streams it
// downstream LANES elements per beat over a valid/ready handshake.
module relu_stream_sequencer #(
    parameter int DATA_WIDTH = 24,
    parameter int NUM_NODES  = 20,
    parameter int LANES      = 4,
    localparam int NUM_BEATS = (NUM_NODES + LANES - 1) / LANES,
    localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1,
    localparam int CNT_W     = $clog2(NUM_NODES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  zin_valid,
    output logic                  zin_ready,
    input  logic [DATA_WIDTH-1:0] zin [NUM_NODES],
    input  logic                  relu_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data [LANES],
    output logic [LANES-1:0]      out_mask,
    output logic [BEAT_W-1:0]     out_beat,
    output logic                  out_last,
    output logic                  done,
    output logic [CNT_W-1:0]      zero_count,
    output logic                  busy
);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_STREAM = 1'b1} state_t;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

    state_t                  r_state;
    state_t                  w_state_nx;
    logic [DATA_WIDTH-1:0]   r_bank [NUM_BEATS][LANES];
    logic [DATA_WIDTH-1:0]   w_bank [NUM_BEATS][LANES];
    logic [LANES-1:0]        r_neg [NUM_BEATS];
    logic [LANES-1:0]        w_neg [NUM_BEATS];
    logic [LANES-1:0]        w_mask_tab [NUM_BEATS];
    logic [BEAT_W-1:0]       r_beat;
    logic [BEAT_W-1:0]       w_beat_nx;
    logic [CNT_W-1:0]        r_acc;
    logic [CNT_W-1:0]        w_beat_cnt;
    logic                    r_out_valid;
    logic [DATA_WIDTH-1:0]   r_out_data [LANES];
    logic [LANES-1:0]        r_out_mask;
    logic                    r_out_last;
    logic                    r_done;
    logic [CNT_W-1:0]        r_zero_count;
    logic                    w_accept;
    logic                    w_fire;
    logic                    w_is_last;

    function automatic logic [CNT_W-1:0] popcount(input logic [LANES-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < LANES; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // ReLU is applied at capture; the bank is laid out beat-major with zeroed padding lanes.
    for (genvar b = 0; b < NUM_BEATS; b++) begin : g_beat
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            localparam int K = b * LANES + i;
            if (K < NUM_NODES) begin : g_real
                assign w_neg[b][i]      = relu_en & zin[K][DATA_WIDTH-1];
                assign w_bank[b][i]     = w_neg[b][i] ? '0 : zin[K];
                assign w_mask_tab[b][i] = 1'b1;
            end else begin : g_pad
                assign w_neg[b][i]      = 1'b0;
                assign w_bank[b][i]     = '0;
                assign w_mask_tab[b][i] = 1'b0;
            end
        end
    end

    assign zin_ready  = (r_state == S_IDLE);
    assign busy       = (r_state == S_STREAM);
    assign w_accept   = zin_valid & (r_state == S_IDLE);
    assign w_fire     = r_out_valid & out_ready & (r_state == S_STREAM);
    assign w_is_last  = (r_beat == LAST_BEAT);
    assign w_beat_nx  = w_is_last ? '0 : r_beat + 1'b1;
    assign w_beat_cnt = popcount(r_neg[r_beat]);

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_mask   = r_out_mask;
    assign out_beat   = r_beat;
    assign out_last   = r_out_last;
    assign done       = r_done;
    assign zero_count = r_zero_count;

    // Next-state logic
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (zin_valid) w_state_nx = S_STREAM;
                else           w_state_nx = S_IDLE;
            end
            S_STREAM: begin
                if (w_fire && w_is_last) w_state_nx = S_IDLE;
                else                     w_state_nx = S_STREAM;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    // Capture bank, beat sequencing, registered outputs and clamp accounting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BEATS; b++) begin
                r_neg[b] <= '0;
                for (int i = 0; i < LANES; i++) r_bank[b][i] <= '0;
            end
            for (int i = 0; i < LANES; i++) r_out_data[i] <= '0;
            r_beat       <= '0;
            r_acc        <= '0;
            r_out_valid  <= 1'b0;
            r_out_mask   <= '0;
            r_out_last   <= 1'b0;
            r_done       <= 1'b0;
            r_zero_count <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_bank      <= w_bank;
                r_neg       <= w_neg;
                r_beat      <= '0;
                r_acc       <= '0;
                r_out_valid <= 1'b1;
                r_out_data  <= w_bank[0];
                r_out_mask  <= w_mask_tab[0];
                r_out_last  <= (NUM_BEATS == 1);
            end else if (w_fire) begin
                r_acc <= r_acc + w_beat_cnt;
                if (w_is_last) begin
                    for (int i = 0; i < LANES; i++) r_out_data[i] <= '0;
                    r_beat       <= '0;
                    r_out_valid  <= 1'b0;
                    r_out_mask   <= '0;
                    r_out_last   <= 1'b0;
                    r_done       <= 1'b1;
                    r_zero_count <= r_acc + w_beat_cnt;
                end else begin
                    r_beat     <= w_beat_nx;
                    r_out_data <= r_bank[w_beat_nx];
                    r_out_mask <= w_mask_tab[w_beat_nx];
                    r_out_last <= (w_beat_nx == LAST_BEAT);
                end
            end else begin
                r_acc <= r_acc;
            end
        end
    end

endmodule

// File: tb/tb_relu_stream_sequencer.sv
// Bench for relu_stream_sequencer: default 20x4 instance plus a 10x4 instance for partial beats.
module tb_relu_stream_sequencer;

    localparam int DW = 24, N = 20, L = 4, NB = 5, PN = 10, PNB = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          zin_valid, zin_ready, relu_en, out_valid, out_ready, out_last, done, busy;
    logic [DW-1:0] zin [N];
    logic [DW-1:0] out_data [L];
    logic [L-1:0]  out_mask;
    logic [2:0]    out_beat;
    logic [4:0]    zero_count;

    logic          p_zin_valid, p_zin_ready, p_relu_en, p_out_valid, p_out_ready, p_out_last, p_done, p_busy;
    logic [DW-1:0] p_zin [PN];
    logic [DW-1:0] p_out_data [L];
    logic [L-1:0]  p_out_mask;
    logic [1:0]    p_out_beat;
    logic [3:0]    p_zero_count;

    int errors = 0;
    int checks = 0;

    // bench-side state for the default instance
    logic [DW-1:0] tb_vec [N];
    logic          tb_en;
    logic [DW-1:0] tb_next_vec [N];
    logic          tb_next_en;
    logic [DW-1:0] obs_data [NB+2][L];
    logic [L-1:0]  obs_mask [NB+2];
    logic [2:0]    obs_beat [NB+2];
    logic          obs_last [NB+2];
    int            nobs, hold_err, early_done, iso_err, stall_seen;
    logic          timeout, first_valid, got_done, valid_after, done_after, ready_at_done, accept_ready;
    logic [2:0]    first_beat;
    logic [4:0]    obs_zc;

    relu_stream_sequencer #(.DATA_WIDTH(DW), .NUM_NODES(N), .LANES(L)) dut (
        .clk(clk), .rst(rst), .zin_valid(zin_valid), .zin_ready(zin_ready), .zin(zin),
        .relu_en(relu_en), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_mask(out_mask), .out_beat(out_beat), .out_last(out_last), .done(done),
        .zero_count(zero_count), .busy(busy));

    relu_stream_sequencer #(.DATA_WIDTH(DW), .NUM_NODES(PN), .LANES(L)) dut_p (
        .clk(clk), .rst(rst), .zin_valid(p_zin_valid), .zin_ready(p_zin_ready), .zin(p_zin),
        .relu_en(p_relu_en), .out_valid(p_out_valid), .out_ready(p_out_ready), .out_data(p_out_data),
        .out_mask(p_out_mask), .out_beat(p_out_beat), .out_last(p_out_last), .done(p_done),
        .zero_count(p_zero_count), .busy(p_busy));

    always #5 clk = ~clk;

    // Reference: ReLU clamps negatives to zero, bypass passes everything.
    function automatic logic [DW-1:0] ref_elem(input logic [DW-1:0] x, input logic en);
        if (en && ($signed(x) < 0)) return '0;
        return x;
    endfunction

    function automatic int ref_count(input logic [DW-1:0] v [N], input logic en);
        int c = 0;
        for (int k = 0; k < N; k++) if (en && ($signed(v[k]) < 0)) c++;
        return c;
    endfunction

    // Drives one vector (unless already accepted) and records every handshaken beat.
    // mode 0: always ready, 1: random ready, 2: stall 3 cycles on stall_beat.
    task automatic run_vec(input int mode, input int stall_beat, input bit isolate,
                           input bit chain, input bit skip_accept);
        int cyc = 0, stall_left = 3;
        bit last_hs = 1'b0, prev_stall = 1'b0, rdy;
        logic [DW-1:0] s_data [L];
        logic [L-1:0] s_mask;
        logic [2:0] s_beat;
        logic s_last;
        nobs = 0; hold_err = 0; early_done = 0; iso_err = 0; stall_seen = 0; timeout = 1'b0;
        if (!skip_accept) begin
            for (int k = 0; k < N; k++) zin[k] = tb_vec[k];
            relu_en = tb_en; zin_valid = 1'b1; out_ready = 1'b0;
            accept_ready = zin_ready;
            @(posedge clk); #1;
            zin_valid = 1'b0;
        end
        first_valid = out_valid;
        first_beat  = out_beat;
        while (!last_hs && !timeout) begin
            if (isolate) begin
                if (zin_ready !== 1'b0) iso_err++;
                zin_valid = 1'($urandom_range(0, 1));
                relu_en   = 1'($urandom_range(0, 1));
                for (int k = 0; k < N; k++) zin[k] = DW'($urandom);
            end
            if (mode == 2 && out_valid && out_beat == 3'(stall_beat) && stall_left > 0) begin
                rdy = 1'b0; stall_left--;
            end else if (mode == 1) rdy = 1'($urandom_range(0, 1));
            else rdy = 1'b1;
            out_ready = rdy;
            if (out_valid && !rdy) stall_seen++;
            if (done) early_done++;
            if (prev_stall) begin
                if (out_valid !== 1'b1 || out_beat !== s_beat || out_last !== s_last || out_mask !== s_mask)
                    hold_err++;
                for (int i = 0; i < L; i++) if (out_data[i] !== s_data[i]) hold_err++;
            end
            for (int i = 0; i < L; i++) s_data[i] = out_data[i];
            s_mask = out_mask; s_beat = out_beat; s_last = out_last;
            prev_stall = out_valid && !rdy;
            if (out_valid && rdy && nobs < NB + 2) begin
                for (int i = 0; i < L; i++) obs_data[nobs][i] = out_data[i];
                obs_mask[nobs] = out_mask; obs_beat[nobs] = out_beat; obs_last[nobs] = out_last;
                nobs++;
                last_hs = out_last;
            end
            @(posedge clk); #1;
            cyc++;
            if (cyc > 200) timeout = 1'b1;
        end
        out_ready = 1'b0; zin_valid = 1'b0;
        got_done = done; obs_zc = zero_count; valid_after = out_valid; ready_at_done = zin_ready;
        if (chain) begin
            for (int k = 0; k < N; k++) zin[k] = tb_next_vec[k];
            relu_en = tb_next_en; zin_valid = 1'b1;
        end
        @(posedge clk); #1;
        zin_valid = 1'b0;
        done_after = done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_mask !== 4'h0 || out_beat !== 3'd0 || out_last !== 1'b0 ||
            done !== 1'b0 || zero_count !== 5'd0 || busy !== 1'b0 || zin_ready !== 1'b1)
            begin errors++; $display("FAIL reset_ctrl: valid=%b mask=%h beat=%0d last=%b done=%b zc=%0d busy=%b rdy=%b, want 0 0 0 0 0 0 0 1",
                out_valid, out_mask, out_beat, out_last, done, zero_count, busy, zin_ready); end
        for (int i = 0; i < L; i++) begin
            checks++;
            if (out_data[i] !== '0) begin errors++; $display("FAIL reset_data lane%0d: got %h want 0", i, out_data[i]); end
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_relu();
        for (int k = 0; k < N; k++) tb_vec[k] = DW'(k - 10);
        tb_en = 1'b1;
        run_vec(0, -1, 1'b0, 1'b0, 1'b0);
        checks++; if (accept_ready !== 1'b1) begin errors++; $display("FAIL basic zin_ready: got %b want 1", accept_ready); end
        checks++; if (first_valid !== 1'b1) begin errors++; $display("FAIL basic latency: out_valid=%b want 1", first_valid); end
        checks++; if (nobs !== NB || timeout) begin errors++; $display("FAIL basic beats: got %0d want %0d (timeout=%b)", nobs, NB, timeout); end
        for (int b = 0; b < nobs && b < NB; b++) begin
            checks++;
            if (obs_beat[b] !== 3'(b) || obs_last[b] !== (b == NB - 1) || obs_mask[b] !== 4'hF)
                begin errors++; $display("FAIL basic hdr%0d: beat=%0d last=%b mask=%h want %0d %b f", b, obs_beat[b], obs_last[b], obs_mask[b], b, b == NB - 1); end
            for (int i = 0; i < L; i++) begin
                checks++;
                if (obs_data[b][i] !== ref_elem(tb_vec[b*L+i], tb_en))
                    begin errors++; $display("FAIL basic elem%0d: got %h want %h", b*L+i, obs_data[b][i], ref_elem(tb_vec[b*L+i], tb_en)); end
            end
        end
        checks++; if (obs_data[4][3] !== 24'd9 || obs_data[2][2] !== 24'd0) begin errors++; $display("FAIL basic spot: e19=%h e10=%h want 9 0", obs_data[4][3], obs_data[2][2]); end
        checks++; if (got_done !== 1'b1 || obs_zc !== 5'd10 || valid_after !== 1'b0)
            begin errors++; $display("FAIL basic done: done=%b zc=%0d valid=%b want 1 10 0", got_done, obs_zc, valid_after); end
        checks++; if (done_after !== 1'b0 || early_done !== 0) begin errors++; $display("FAIL basic pulse: after=%b early=%0d want 0 0", done_after, early_done); end
        checks++; if (zero_count !== 5'd10) begin errors++; $display("FAIL basic zc_hold: got %0d want 10", zero_count); end
    endtask

    task automatic test_bypass();
        for (int k = 0; k < N; k++) tb_vec[k] = DW'(k - 10);
        tb_en = 1'b0;
        run_vec(0, -1, 1'b0, 1'b0, 1'b0);
        checks++; if (nobs !== NB) begin errors++; $display("FAIL bypass beats: got %0d want %0d", nobs, NB); end
        for (int b = 0; b < nobs && b < NB; b++)
            for (int i = 0; i < L; i++) begin
                checks++;
                if (obs_data[b][i] !== DW'(b*L + i - 10))
                    begin errors++; $display("FAIL bypass elem%0d: got %h want %h", b*L+i, obs_data[b][i], DW'(b*L + i - 10)); end
            end
        checks++; if (got_done !== 1'b1 || obs_zc !== 5'd0) begin errors++; $display("FAIL bypass done: done=%b zc=%0d want 1 0", got_done, obs_zc); end
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < N; k++) tb_vec[k] = DW'($urandom);
        tb_en = 1'b1;
        run_vec(2, 2, 1'b0, 1'b0, 1'b0);
        checks++; if (stall_seen !== 3 || hold_err !== 0) begin errors++; $display("FAIL bp hold: stalls=%0d hold_err=%0d want 3 0", stall_seen, hold_err); end
        checks++; if (nobs !== NB) begin errors++; $display("FAIL bp beats: got %0d want %0d", nobs, NB); end
        for (int b = 0; b < nobs && b < NB; b++) begin
            checks++; if (obs_beat[b] !== 3'(b)) begin errors++; $display("FAIL bp beat%0d: got %0d", b, obs_beat[b]); end
            for (int i = 0; i < L; i++) begin
                checks++;
                if (obs_data[b][i] !== ref_elem(tb_vec[b*L+i], tb_en))
                    begin errors++; $display("FAIL bp elem%0d: got %h want %h", b*L+i, obs_data[b][i], ref_elem(tb_vec[b*L+i], tb_en)); end
            end
        end
        checks++; if (got_done !== 1'b1 || 32'(obs_zc) !== ref_count(tb_vec, tb_en))
            begin errors++; $display("FAIL bp zc: done=%b zc=%0d want 1 %0d", got_done, obs_zc, ref_count(tb_vec, tb_en)); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < N; k++) tb_vec[k] = (k == t) ? '0 : DW'($urandom);
            tb_en = (t < 4) ? 1'b1 : 1'($urandom_range(0, 1));
            run_vec(1, -1, 1'b0, 1'b0, 1'b0);
            checks++; if (nobs !== NB || hold_err !== 0 || timeout)
                begin errors++; $display("FAIL rand%0d stream: beats=%0d hold_err=%0d timeout=%b want %0d 0 0", t, nobs, hold_err, timeout, NB); end
            for (int b = 0; b < nobs && b < NB; b++) begin
                checks++; if (obs_beat[b] !== 3'(b) || obs_last[b] !== (b == NB - 1))
                    begin errors++; $display("FAIL rand%0d hdr%0d: beat=%0d last=%b", t, b, obs_beat[b], obs_last[b]); end
                for (int i = 0; i < L; i++) begin
                    checks++;
                    if (obs_data[b][i] !== ref_elem(tb_vec[b*L+i], tb_en))
                        begin errors++; $display("FAIL rand%0d elem%0d: got %h want %h", t, b*L+i, obs_data[b][i], ref_elem(tb_vec[b*L+i], tb_en)); end
                end
            end
            checks++; if (got_done !== 1'b1 || 32'(obs_zc) !== ref_count(tb_vec, tb_en))
                begin errors++; $display("FAIL rand%0d zc: done=%b zc=%0d want 1 %0d", t, got_done, obs_zc, ref_count(tb_vec, tb_en)); end
        end
    endtask

    task automatic test_isolation();
        for (int k = 0; k < N; k++) begin
            tb_vec[k] = DW'($urandom);
            tb_next_vec[k] = DW'($urandom);
        end
        tb_en = 1'b1; tb_next_en = 1'b1;
        run_vec(0, -1, 1'b1, 1'b1, 1'b0);
        checks++; if (iso_err !== 0) begin errors++; $display("FAIL iso ready: %0d cycles with zin_ready=1 during stream, want 0", iso_err); end
        checks++; if (nobs !== NB) begin errors++; $display("FAIL iso beats: got %0d want %0d", nobs, NB); end
        for (int b = 0; b < nobs && b < NB; b++)
            for (int i = 0; i < L; i++) begin
                checks++;
                if (obs_data[b][i] !== ref_elem(tb_vec[b*L+i], tb_en))
                    begin errors++; $display("FAIL iso elem%0d: got %h want %h", b*L+i, obs_data[b][i], ref_elem(tb_vec[b*L+i], tb_en)); end
            end
        checks++; if (got_done !== 1'b1 || ready_at_done !== 1'b1 || 32'(obs_zc) !== ref_count(tb_vec, tb_en))
            begin errors++; $display("FAIL iso done: done=%b rdy=%b zc=%0d want 1 1 %0d", got_done, ready_at_done, obs_zc, ref_count(tb_vec, tb_en)); end
        for (int k = 0; k < N; k++) tb_vec[k] = tb_next_vec[k];
        tb_en = tb_next_en;
        run_vec(0, -1, 1'b0, 1'b0, 1'b1);
        checks++; if (first_valid !== 1'b1 || first_beat !== 3'd0 || nobs !== NB)
            begin errors++; $display("FAIL chain start: valid=%b beat=%0d beats=%0d want 1 0 %0d", first_valid, first_beat, nobs, NB); end
        for (int b = 0; b < nobs && b < NB; b++)
            for (int i = 0; i < L; i++) begin
                checks++;
                if (obs_data[b][i] !== ref_elem(tb_vec[b*L+i], tb_en))
                    begin errors++; $display("FAIL chain elem%0d: got %h want %h", b*L+i, obs_data[b][i], ref_elem(tb_vec[b*L+i], tb_en)); end
            end
        checks++; if (got_done !== 1'b1 || 32'(obs_zc) !== ref_count(tb_vec, tb_en))
            begin errors++; $display("FAIL chain zc: done=%b zc=%0d want 1 %0d", got_done, obs_zc, ref_count(tb_vec, tb_en)); end
    endtask

    task automatic test_reset_midstream();
        int dn = 0;
        for (int k = 0; k < N; k++) zin[k] = DW'(k + 100);
        relu_en = 1'b0; zin_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        zin_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_beat !== 3'd1 || out_data[0] !== DW'(104)) begin errors++; $display("FAIL rstmid pre: beat=%0d lane0=%h want 1 68", out_beat, out_data[0]); end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_beat !== 3'd0 || out_mask !== 4'h0 || out_data[0] !== '0 || done !== 1'b0)
            begin errors++; $display("FAIL rstmid async: valid=%b busy=%b beat=%0d mask=%h lane0=%h done=%b want all 0", out_valid, busy, out_beat, out_mask, out_data[0], done); end
        repeat (2) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        checks++; if (dn !== 0) begin errors++; $display("FAIL rstmid done: %0d done pulses, want 0", dn); end
        for (int k = 0; k < N; k++) tb_vec[k] = DW'($urandom);
        tb_en = 1'b1;
        run_vec(0, -1, 1'b0, 1'b0, 1'b0);
        checks++; if (first_beat !== 3'd0 || nobs !== NB) begin errors++; $display("FAIL rstmid restart: beat=%0d beats=%0d want 0 %0d", first_beat, nobs, NB); end
        for (int b = 0; b < nobs && b < NB; b++)
            for (int i = 0; i < L; i++) begin
                checks++;
                if (obs_data[b][i] !== ref_elem(tb_vec[b*L+i], tb_en))
                    begin errors++; $display("FAIL rstmid elem%0d: got %h want %h", b*L+i, obs_data[b][i], ref_elem(tb_vec[b*L+i], tb_en)); end
            end
        checks++; if (got_done !== 1'b1 || 32'(obs_zc) !== ref_count(tb_vec, tb_en))
            begin errors++; $display("FAIL rstmid zc: done=%b zc=%0d want 1 %0d", got_done, obs_zc, ref_count(tb_vec, tb_en)); end
    endtask

    task automatic test_partial();
        logic [DW-1:0] exp_v;
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < PN; k++) p_zin[k] = 24'hFFFFFF;
            p_relu_en = (m == 0); p_zin_valid = 1'b1; p_out_ready = 1'b1;
            @(posedge clk); #1;
            p_zin_valid = 1'b0;
            for (int b = 0; b < PNB; b++) begin
                checks++;
                if (p_out_valid !== 1'b1 || p_out_beat !== 2'(b) || p_out_last !== (b == PNB - 1) ||
                    p_out_mask !== ((b == PNB - 1) ? 4'b0011 : 4'b1111))
                    begin errors++; $display("FAIL partial%0d hdr%0d: valid=%b beat=%0d last=%b mask=%b", m, b, p_out_valid, p_out_beat, p_out_last, p_out_mask); end
                for (int i = 0; i < L; i++) begin
                    exp_v = (b*L + i >= PN || m == 0) ? 24'h0 : 24'hFFFFFF;
                    checks++;
                    if (p_out_data[i] !== exp_v)
                        begin errors++; $display("FAIL partial%0d b%0d lane%0d: got %h want %h", m, b, i, p_out_data[i], exp_v); end
                end
                @(posedge clk); #1;
            end
            checks++;
            if (p_done !== 1'b1 || p_out_valid !== 1'b0 || p_zero_count !== ((m == 0) ? 4'd10 : 4'd0))
                begin errors++; $display("FAIL partial%0d done: done=%b valid=%b zc=%0d want 1 0 %0d", m, p_done, p_out_valid, p_zero_count, (m == 0) ? 10 : 0); end
            p_out_ready = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        zin_valid = 1'b0; relu_en = 1'b0; out_ready = 1'b0;
        p_zin_valid = 1'b0; p_relu_en = 1'b0; p_out_ready = 1'b0;
        for (int k = 0; k < N; k++) zin[k] = '0;
        for (int k = 0; k < PN; k++) p_zin[k] = '0;
        test_reset();
        test_basic_relu();
        test_bypass();
        test_backpressure();
        test_random();
        test_isolation();
        test_partial();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
